// File: rtl/of_pkg.sv
// of_pkg: widths and pixel type shared by the optical-flow alignment and smoothing stages.
package of_pkg;
    function automatic int cw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    localparam int NUM_CH      = 2;
    localparam int VALUE_WIDTH = 12;
    localparam int PIX_W       = NUM_CH * VALUE_WIDTH;
    localparam int X_W         = cw(640);
    localparam int Y_W         = cw(480);
    typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/of_flow_align_if.sv
// of_flow_align_if: pixel stream in, aligned and border-tagged pixel stream out.
interface of_flow_align_if import of_pkg::*; #(
    parameter int DW = PIX_W,
    parameter int XW = X_W,
    parameter int YW = Y_W
);
    logic          en;
    logic          sof_in;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          sof_out;
    logic          eol_out;
    logic          border_out;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic          resync_err;
    modport master (
        output en, sof_in, data_in,
        input  data_out, valid_out, sof_out, eol_out, border_out, x_out, y_out, resync_err
    );
    modport slave (
        input  en, sof_in, data_in,
        output data_out, valid_out, sof_out, eol_out, border_out, x_out, y_out, resync_err
    );
endinterface

// File: rtl/of_delay_line.sv
// of_delay_line: en-qualified DEPTH-stage delay; deep lines use a read-before-write RAM ring.
module of_delay_line #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH <= 16) begin : g_sr
        logic [WIDTH-1:0] sr [DEPTH];
        always_ff @(posedge clk)
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
            end else if (en) begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        assign q = sr[DEPTH-1];
    end else begin : g_ram
        localparam int AW = $clog2(DEPTH - 1);
        logic [WIDTH-1:0] mem [DEPTH-1];
        logic [AW-1:0]    ptr;
        logic [WIDTH-1:0] q_r;
        // Stale RAM contents after reset are masked downstream by the prime count.
        always_ff @(posedge clk)
            if (en) mem[ptr] <= d;
        always_ff @(posedge clk)
            if (rst) begin
                ptr <= '0;
                q_r <= '0;
            end else if (en) begin
                q_r <= mem[ptr];
                ptr <= ptr == AW'(DEPTH - 2) ? '0 : ptr + 1'b1;
            end
        assign q = q_r;
    end
endmodule

// File: rtl/of_flow_align.sv
// of_flow_align: delays flow vectors, locks to sof, tracks (x,y) and zeroes the border.
module of_flow_align import of_pkg::*; #(
    parameter int NUM_CH       = 2,
    parameter int VALUE_WIDTH  = 12,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int LATENCY      = 8,
    parameter int BORDER_X     = 5,
    parameter int BORDER_Y     = 5,
    parameter int BORDER_ZERO  = 1
) (
    input  logic            clk,
    input  logic            rst,
    of_flow_align_if.slave  bus
);
    localparam int DW = NUM_CH * VALUE_WIDTH;
    localparam int XW = cw(FRAME_WIDTH);
    localparam int YW = cw(FRAME_HEIGHT);
    localparam int PW = $clog2(LATENCY + 1);
    localparam logic [XW-1:0] X_MAX = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(FRAME_HEIGHT - 1);
    localparam logic [XW-1:0] X_LO  = XW'(BORDER_X);
    localparam logic [XW-1:0] X_HI  = XW'(FRAME_WIDTH - BORDER_X);
    localparam logic [YW-1:0] Y_LO  = YW'(BORDER_Y);
    localparam logic [YW-1:0] Y_HI  = YW'(FRAME_HEIGHT - BORDER_Y);
    localparam logic [PW-1:0] P_MAX = PW'(LATENCY - 1);
    logic [DW:0]    dly;
    logic           d_sof;
    logic [DW-1:0]  d_data;
    logic [PW-1:0]  cnt;
    logic           locked;
    logic           primed, emit, wrap, bord;
    logic [XW-1:0]  nx;
    logic [YW-1:0]  ny;
    // The output register is the last stage, so the line itself is one shorter.
    if (LATENCY > 1) begin : g_dly
        of_delay_line #(.WIDTH(DW + 1), .DEPTH(LATENCY - 1)) u_dly (
            .clk (clk),
            .rst (rst),
            .en  (bus.en),
            .d   ({bus.sof_in, bus.data_in}),
            .q   (dly)
        );
    end else begin : g_nodly
        assign dly = {bus.sof_in, bus.data_in};
    end
    assign {d_sof, d_data} = dly;
    always_comb begin
        primed = cnt == P_MAX;
        emit   = bus.en && primed && (d_sof || locked);
        wrap   = bus.x_out == X_MAX;
        nx     = d_sof ? '0 : (wrap ? '0 : bus.x_out + 1'b1);
        ny     = d_sof ? '0 : (wrap ? bus.y_out + 1'b1 : bus.y_out);
        bord   = nx < X_LO || nx >= X_HI || ny < Y_LO || ny >= Y_HI;
    end
    always_ff @(posedge clk)
        if (rst) begin
            cnt            <= '0;
            locked         <= 1'b0;
            bus.valid_out  <= 1'b0;
            bus.sof_out    <= 1'b0;
            bus.eol_out    <= 1'b0;
            bus.border_out <= 1'b0;
            bus.x_out      <= '0;
            bus.y_out      <= '0;
            bus.data_out   <= '0;
            bus.resync_err <= 1'b0;
        end else begin
            bus.valid_out <= emit;
            if (bus.en && !primed) cnt <= cnt + 1'b1;
            if (emit) begin
                bus.x_out      <= nx;
                bus.y_out      <= ny;
                bus.sof_out    <= d_sof;
                bus.eol_out    <= nx == X_MAX;
                bus.border_out <= bord;
                bus.data_out   <= (bord && BORDER_ZERO != 0) ? '0 : d_data;
                locked         <= !(nx == X_MAX && ny == Y_MAX);
                if (d_sof && locked) bus.resync_err <= 1'b1;
            end
        end
endmodule

// File: doc/of_flow_align.md
OF_FLOW_ALIGN -- requirements
Module: of_flow_align

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  NUM_CH 2 (vector channels, e.g. vx, vy)
  VALUE_WIDTH 12 (bits per channel, two's complement)
  FRAME_WIDTH 640 (pixels per line)
  FRAME_HEIGHT 480 (lines per frame)
  LATENCY 8 (en-qualified delay, >=1)
  BORDER_X 5 (invalid columns at each side)
  BORDER_Y 5 (invalid rows at top and bottom)
  BORDER_ZERO 1 (1 = zero border data; 0 = pass border data)
REQ-002 Ports (name, direction, width, meaning), one per line; clock and reset first:
  clk  in  1  single clock
  rst  in  1  reset, synchronous, active-high
  en  in  1  pixel strobe; the pipeline advances only when en=1
  sof_in  in  1  first pixel of frame, qualified by en
  data_in  in  NUM_CH*VALUE_WIDTH  packed channels, ch0 at LSBs
  data_out  out  NUM_CH*VALUE_WIDTH  aligned, border-processed data
  valid_out  out  1  data_out holds a new pixel this cycle
  sof_out  out  1  pixel (0,0), qualified by valid_out
  eol_out  out  1  last pixel of line, qualified by valid_out
  border_out  out  1  pixel lies in the border region
  x_out  out  clog2(FRAME_WIDTH)  output column
  y_out  out  clog2(FRAME_HEIGHT)  output row
  resync_err  out  1  sticky flag: sof arrived mid-frame

Function
REQ-003 The delay line SHALL shift {sof_in, data_in} by one stage on each en=1 cycle; it SHALL hold when en=0.
REQ-004 A sample accepted on en-pulse n SHALL be registered onto the outputs on en-pulse n+LATENCY-1. valid_out SHALL be high in the following cycle only.
REQ-005 The block SHALL be primed after LATENCY en-pulses following reset. valid_out SHALL stay 0 until the block is primed.
REQ-006 Until the first delayed sof emerges, the block SHALL be unlocked and valid_out SHALL stay 0. The first emerging sof SHALL lock the block.
REQ-007 An emerging sof SHALL set x=0 and y=0 and SHALL assert sof_out. Each other output pixel SHALL increment x. When x=FRAME_WIDTH-1, eol_out SHALL assert and the next pixel SHALL set x=0 and increment y.
REQ-008 After pixel (FRAME_WIDTH-1, FRAME_HEIGHT-1), the block SHALL unlock. Following pixels SHALL be dropped (valid_out=0) until the next sof.
REQ-009 A sof that emerges while locked, at any position other than the one just after the frame end, SHALL resync the counters to (0,0), SHALL output the pixel as sof, and SHALL set resync_err.
REQ-010 border_out SHALL be 1 when any of these holds: x<BORDER_X, x>=FRAME_WIDTH-BORDER_X, y<BORDER_Y, y>=FRAME_HEIGHT-BORDER_Y.
REQ-011 When BORDER_ZERO=1 and border_out=1, data_out SHALL be all zeros. Otherwise data_out SHALL equal the delayed data unchanged.
REQ-012 x_out, y_out, sof_out, eol_out and border_out SHALL describe the pixel currently on data_out. They SHALL hold their values while valid_out=0.
REQ-013 When en=1 on consecutive cycles, the block SHALL accept one pixel per cycle with no bubbles.

Reset
REQ-014 On rst=1 at a clk edge, the block SHALL set all outputs to 0, clear the delay line and the prime count, unlock, and clear resync_err.
REQ-015 rst SHALL take priority over en. A reset mid-frame SHALL discard all in-flight pixels.

Structure
REQ-016 A shared package of_pkg SHALL hold the clog2-derived width constants and a typedef for packed vector pixels. This package SHALL be reused by of_flow_align and by the spatial smoothing stages.
REQ-017 The delay line SHALL be the sub-module of_delay_line (parameters WIDTH and DEPTH, shifting on en). Depth beyond 16 SHALL map to block RAM.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
  Reset, then en held high with sof on pulse 0 (LATENCY=8) -> first valid_out with sof_out=1, x=0, y=0 exactly 8 cycles after the sof cycle.
  en toggled 1-0-1-0 -> output pixel order and values identical to the continuous-en case; valid_out pulses only after en cycles.
  Full 16x8 frame (FRAME_WIDTH=16, FRAME_HEIGHT=8, BORDER_X=2, BORDER_Y=1, ramp data) -> eol_out at x=15 on each row; data_out=0 at columns 0,1,14,15 and rows 0,7; other pixels equal the ramp value.
  sof injected at input pixel 37 of the 16x8 frame -> resync_err=1, counters restart at (0,0), no valid_out lost.
  Pixels after frame end with no sof -> valid_out stays 0 until the next sof.
  rst asserted mid-frame, then a new frame started -> outputs 0, valid_out 0 for 8 en-pulses, then normal lock on the new sof.
